// File: rtl/key_schedule_collector.sv
// key_schedule_collector
// Reassembles the two 1024-bit halves of an AES round-key schedule into one
// 2048-bit word and presents it downstream with a valid/ready handshake.
// The block holds one schedule in the assembly buffer while another waits in
// the output register.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   ivalid     input beat valid
//   oready     block can accept an input beat this cycle
//   datain     half-schedule payload
//   flagin     8'h01 = lower half, 8'h02 = upper half, anything else illegal
//   flush      synchronous clear of the assembly buffer (output untouched)
//   ovalid     dataout holds a complete schedule
//   iready     downstream accepts dataout
//   dataout    {upper, lower} schedule
//   key_count  schedules delivered, wraps
//   err_flag   one-cycle pulse after an illegal flag or duplicate half
//
// Assembly state
//   state   | meaning
//   EMPTY   | no half present
//   HAVE_LO | lower half buffered
//   HAVE_HI | upper half buffered
//   FULL    | both halves buffered, waiting for the output register
module key_schedule_collector #(
  parameter int KEY_WIDTH  = 256,
  parameter int HALF_WIDTH = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ivalid,
  output logic                    oready,
  input  logic [HALF_WIDTH-1:0]   datain,
  input  logic [7:0]              flagin,
  input  logic                    flush,
  output logic                    ovalid,
  input  logic                    iready,
  output logic [2*HALF_WIDTH-1:0] dataout,
  output logic [CNT_WIDTH-1:0]    key_count,
  output logic                    err_flag
);

  if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_key
    $error("key_schedule_collector: KEY_WIDTH must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    HAVE_LO = 2'b01,
    HAVE_HI = 2'b10,
    FULL    = 2'b11
  } state_t;

  state_t                  state, state_nxt;
  logic                    rst_done;
  logic [HALF_WIDTH-1:0]   lo_buf, hi_buf;
  logic [HALF_WIDTH-1:0]   merge_lo, merge_hi;
  logic                    lo_v, hi_v;
  logic                    accept, hs, out_free;
  logic                    lo_we, hi_we, bad_flag;
  logic                    load_out, ovalid_nxt, err_nxt;
  logic [1:0]              present_nxt;

  // The state encoding is exactly the presence bits {hi_v, lo_v}.
  assign lo_v = state[0];
  assign hi_v = state[1];

  // rst_done keeps oready low until the first edge after reset releases.
  assign oready   = !reset && rst_done && (state != FULL);
  assign accept   = ivalid && oready;
  assign hs       = ovalid && iready;
  assign out_free = !ovalid || hs;

  // A beat accepted together with flush is discarded silently.
  assign lo_we    = accept && !flush && (flagin == 8'h01);
  assign hi_we    = accept && !flush && (flagin == 8'h02);
  assign bad_flag = accept && !flush && (flagin != 8'h01) && (flagin != 8'h02);

  // The completing beat bypasses the buffer straight into dataout.
  assign merge_lo = lo_we ? datain : lo_buf;
  assign merge_hi = hi_we ? datain : hi_buf;
  assign present_nxt = {hi_v | hi_we, lo_v | lo_we};

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    ovalid_nxt = ovalid && !hs;
    err_nxt    = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (state == FULL) begin
      if (hs) begin
        load_out   = 1'b1;
        ovalid_nxt = 1'b1;
        state_nxt  = EMPTY;
      end
    end else if (accept) begin
      err_nxt = bad_flag || (lo_we && lo_v) || (hi_we && hi_v);
      if (present_nxt == 2'b11) begin
        if (out_free) begin
          load_out   = 1'b1;
          ovalid_nxt = 1'b1;
          state_nxt  = EMPTY;
        end else begin
          state_nxt  = FULL;
        end
      end else begin
        state_nxt = state_t'(present_nxt);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      rst_done  <= 1'b0;
      lo_buf    <= '0;
      hi_buf    <= '0;
      dataout   <= '0;
      ovalid    <= 1'b0;
      err_flag  <= 1'b0;
      key_count <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (lo_we) lo_buf <= datain;
      if (hi_we) hi_buf <= datain;
      if (load_out) dataout <= {merge_hi, merge_lo};
      ovalid   <= ovalid_nxt;
      err_flag <= err_nxt;
      if (hs) key_count <= key_count + CNT_WIDTH'(1);
    end
  end

endmodule
